// File: rtl/baccarat_datapath.sv
// Baccarat card datapath: deck, six card registers, mod-10 hand scores, dealt counter and sticky misuse flag.
// A load lands one edge after it is sampled and scores follow combinationally; define BACCARAT_DEAL_LFSR_EN for an LFSR deck.
module baccarat_datapath (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic [2:0] cards_dealt,
  output logic       deal_error
);

  logic [3:0] card;

`ifdef BACCARAT_DEAL_LFSR_EN
  logic [7:0] lfsr;
  logic [7:0] lfsr_mod;

  // Fibonacci LFSR, taps 8,6,5,4; never reaches zero from a nonzero seed.
  always_ff @(posedge slow_clock) begin
    if (reset) lfsr <= 8'h01;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign lfsr_mod = lfsr % 8'd13;
  assign card     = lfsr_mod[3:0] + 4'd1;
`else
  logic [3:0] deck;

  always_ff @(posedge slow_clock) begin
    if (reset) deck <= 4'd1;
    else       deck <= (deck == 4'd13) ? 4'd1 : deck + 4'd1;
  end

  assign card = deck;
`endif

  logic [5:0] load;
  logic [5:0] accept;
  logic [5:0] reject;
  logic [3:0] slot [6];
  logic [2:0] n_accept;
  logic [3:0] dealt_sum;

  assign load = {load_dcard3, load_dcard2, load_dcard1,
                 load_pcard3, load_pcard2, load_pcard1};

  always_comb begin
    accept   = '0;
    reject   = '0;
    n_accept = '0;
    for (int i = 0; i < 6; i++) begin
      accept[i] = load[i] && (slot[i] == 4'd0);
      reject[i] = load[i] && (slot[i] != 4'd0);
      n_accept  = n_accept + {2'b00, accept[i]};
    end
  end

  assign dealt_sum = {1'b0, cards_dealt} + {1'b0, n_accept};

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) slot[i] <= 4'd0;
      cards_dealt <= 3'd0;
      deal_error  <= 1'b0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (accept[i]) slot[i] <= card;
      end
      cards_dealt <= (dealt_sum > 4'd6) ? 3'd6 : dealt_sum[2:0];
      if (|reject) deal_error <= 1'b1;
    end
  end

  assign pcard1 = slot[0];
  assign pcard2 = slot[1];
  assign pcard3 = slot[2];
  assign dcard1 = slot[3];
  assign dcard2 = slot[4];
  assign dcard3 = slot[5];

  // Face cards and tens count zero, as does an empty slot.
  function automatic logic [3:0] card_val(input logic [3:0] c);
    return (c <= 4'd9) ? c : 4'd0;
  endfunction

  function automatic logic [3:0] hand_score(input logic [3:0] c1, input logic [3:0] c2,
                                            input logic [3:0] c3);
    logic [4:0] sum;
    logic [4:0] rem;
    sum = {1'b0, card_val(c1)} + {1'b0, card_val(c2)} + {1'b0, card_val(c3)};
    rem = sum % 5'd10;
    return rem[3:0];
  endfunction

  assign pscore = hand_score(slot[0], slot[1], slot[2]);
  assign dscore = hand_score(slot[3], slot[4], slot[5]);

endmodule

// File: tb/tb_baccarat_datapath.sv
// Bench for baccarat_datapath: directed hands plus random load patterns against a rule-level model.
module tb_baccarat_datapath;

  logic       slow_clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] ld = '0;  // {d3,d2,d1,p3,p2,p1}
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, pscore, dscore;
  logic [2:0] cards_dealt;
  logic       deal_error;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: hand contents, edges since reset, accepted count, misuse flag.
  int mcard[6];
  int k;
  int mdealt;
  bit merr;

  localparam logic [5:0] P1 = 6'b000001, P2 = 6'b000010, P3 = 6'b000100;
  localparam logic [5:0] D1 = 6'b001000, D2 = 6'b010000, D3 = 6'b100000;

  always #5 slow_clock = ~slow_clock;

  baccarat_datapath dut (
    .slow_clock (slow_clock),
    .reset      (reset),
    .load_pcard1(ld[0]),
    .load_pcard2(ld[1]),
    .load_pcard3(ld[2]),
    .load_dcard1(ld[3]),
    .load_dcard2(ld[4]),
    .load_dcard3(ld[5]),
    .pcard1     (pcard1),
    .pcard2     (pcard2),
    .pcard3     (pcard3),
    .dcard1     (dcard1),
    .dcard2     (dcard2),
    .dcard3     (dcard3),
    .pscore     (pscore),
    .dscore     (dscore),
    .cards_dealt(cards_dealt),
    .deal_error (deal_error)
  );

  function automatic int baccarat_points(input int a, input int b, input int c);
    int total;
    total = 0;
    if (a >= 1 && a <= 9) total += a;
    if (b >= 1 && b <= 9) total += b;
    if (c >= 1 && c <= 9) total += c;
    return total % 10;
  endfunction

  // Reset edge with an optional load pending; leaves reset high, outputs sampled after the edge.
  task automatic do_reset(input logic [5:0] pending);
    @(negedge slow_clock);
    reset = 1'b1;
    ld    = pending;
    @(posedge slow_clock);
    #1;
    foreach (mcard[i]) mcard[i] = 0;
    k      = 0;
    mdealt = 0;
    merr   = 1'b0;
  endtask

  task automatic edge_(input logic [5:0] l);
    int acc;
    @(negedge slow_clock);
    reset = 1'b0;
    ld    = l;
    @(posedge slow_clock);
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      if (l[i]) begin
        if (mcard[i] == 0) begin
          mcard[i] = (k % 13) + 1;
          acc++;
        end else begin
          merr = 1'b1;
        end
      end
    end
    mdealt = (mdealt + acc > 6) ? 6 : mdealt + acc;
    k++;
    #1;
  endtask

  task automatic idle_to(input int target);
    while (k < target) edge_('0);
  endtask

  task automatic test_reset;
    do_reset('0);
    n_cmp++;
    if ({pcard1, pcard2, pcard3, dcard1, dcard2, dcard3} !== 24'h0) begin
      n_bad++;
      $display("FAIL reset_cards: got %h want 000000", {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3});
    end
    n_cmp++;
    if ({pscore, dscore} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_scores: got p=%0d d=%0d want 0 0", pscore, dscore);
    end
    n_cmp++;
    if (cards_dealt !== 3'd0 || deal_error !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_count: got dealt=%0d err=%b want 0 0", cards_dealt, deal_error);
    end
  endtask

  task automatic test_basic_hand;
    do_reset('0);
    edge_(P1); edge_(D1); edge_(P2); edge_(D2);
    n_cmp++;
    if ({pcard1, dcard1, pcard2, dcard2} !== 16'h1234) begin
      n_bad++;
      $display("FAIL basic_cards: got p1=%0d d1=%0d p2=%0d d2=%0d want 1 2 3 4", pcard1, dcard1, pcard2, dcard2);
    end
    n_cmp++;
    if (pscore !== 4'd4 || dscore !== 4'd6) begin
      n_bad++;
      $display("FAIL basic_scores: got p=%0d d=%0d want 4 6", pscore, dscore);
    end
    n_cmp++;
    if (cards_dealt !== 3'd4 || deal_error !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_count: got dealt=%0d err=%b want 4 0", cards_dealt, deal_error);
    end
  endtask

  task automatic test_scores;
    do_reset('0);
    idle_to(8);  edge_(P1);
    idle_to(12); edge_(P2);
    n_cmp++;
    if (pcard1 !== 4'd9 || pcard2 !== 4'd13 || pscore !== 4'd9) begin
      n_bad++;
      $display("FAIL score_two: got p1=%0d p2=%0d ps=%0d want 9 13 9", pcard1, pcard2, pscore);
    end
    idle_to(19); edge_(P3);
    n_cmp++;
    if (pcard3 !== 4'd7 || pscore !== 4'd6) begin
      n_bad++;
      $display("FAIL score_three: got p3=%0d ps=%0d want 7 6", pcard3, pscore);
    end
  endtask

  task automatic test_wrap;
    do_reset('0);
    idle_to(13); edge_(D1);
    n_cmp++;
    if (dcard1 !== 4'd1) begin
      n_bad++;
      $display("FAIL wrap_first: got d1=%0d want 1", dcard1);
    end
    idle_to(25); edge_(D2);
    n_cmp++;
    if (dcard2 !== 4'd13 || dscore !== 4'd1) begin
      n_bad++;
      $display("FAIL wrap_second: got d2=%0d ds=%0d want 13 1", dcard2, dscore);
    end
  endtask

  task automatic test_simultaneous;
    do_reset('0);
    idle_to(5); edge_(P3 | D3);
    n_cmp++;
    if (pcard3 !== 4'd6 || dcard3 !== 4'd6) begin
      n_bad++;
      $display("FAIL simul_cards: got p3=%0d d3=%0d want 6 6", pcard3, dcard3);
    end
    n_cmp++;
    if (cards_dealt !== 3'd2 || deal_error !== 1'b0) begin
      n_bad++;
      $display("FAIL simul_count: got dealt=%0d err=%b want 2 0", cards_dealt, deal_error);
    end
  endtask

  task automatic test_held_strobe;
    do_reset('0);
    edge_(P1); edge_(P1); edge_(P1);
    n_cmp++;
    if (pcard1 !== 4'd1 || cards_dealt !== 3'd1 || deal_error !== 1'b1) begin
      n_bad++;
      $display("FAIL held_strobe: got p1=%0d dealt=%0d err=%b want 1 1 1", pcard1, cards_dealt, deal_error);
    end
    repeat (5) edge_('0);
    n_cmp++;
    if (deal_error !== 1'b1) begin
      n_bad++;
      $display("FAIL held_sticky: got err=%b want 1", deal_error);
    end
  endtask

  task automatic test_reset_mid_hand;
    do_reset('0);
    edge_(P1); edge_(P2); edge_(P3); edge_(D1); edge_(D2); edge_(D3);
    n_cmp++;
    if (cards_dealt !== 3'd6 || {pcard3, dcard3} !== 8'h36) begin
      n_bad++;
      $display("FAIL full_hand: got dealt=%0d p3=%0d d3=%0d want 6 3 6", cards_dealt, pcard3, dcard3);
    end
    edge_(P1);  // misuse so deal_error is set before the reset
    do_reset(6'h3F);
    n_cmp++;
    if ({pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, pscore, dscore} !== 32'h0 ||
        cards_dealt !== 3'd0 || deal_error !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: got cards=%h ps=%0d ds=%0d dealt=%0d err=%b want all 0",
               {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3}, pscore, dscore, cards_dealt, deal_error);
    end
    edge_(P2);
    n_cmp++;
    if (pcard2 !== 4'd1 || pcard1 !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_next: got p2=%0d p1=%0d want 1 0", pcard2, pcard1);
    end
  endtask

  task automatic test_random;
    logic [5:0] l;
    for (int round = 0; round < 8; round++) begin
      do_reset('0);
      for (int cyc = 0; cyc < 40; cyc++) begin
        l = '0;
        for (int b = 0; b < 6; b++) l[b] = ($urandom_range(0, 9) == 0);
        edge_(l);
        n_cmp++;
        if (pcard1 !== 4'(mcard[0]) || pcard2 !== 4'(mcard[1]) || pcard3 !== 4'(mcard[2]) ||
            dcard1 !== 4'(mcard[3]) || dcard2 !== 4'(mcard[4]) || dcard3 !== 4'(mcard[5])) begin
          n_bad++;
          $display("FAIL rand_cards r%0d k%0d: got %0d %0d %0d / %0d %0d %0d want %0d %0d %0d / %0d %0d %0d",
                   round, k, pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
                   mcard[0], mcard[1], mcard[2], mcard[3], mcard[4], mcard[5]);
        end
        n_cmp++;
        if (pscore !== 4'(baccarat_points(mcard[0], mcard[1], mcard[2])) ||
            dscore !== 4'(baccarat_points(mcard[3], mcard[4], mcard[5]))) begin
          n_bad++;
          $display("FAIL rand_scores r%0d k%0d: got p=%0d d=%0d want %0d %0d", round, k, pscore, dscore,
                   baccarat_points(mcard[0], mcard[1], mcard[2]), baccarat_points(mcard[3], mcard[4], mcard[5]));
        end
        n_cmp++;
        if (cards_dealt !== 3'(mdealt) || deal_error !== merr) begin
          n_bad++;
          $display("FAIL rand_status r%0d k%0d: got dealt=%0d err=%b want %0d %b",
                   round, k, cards_dealt, deal_error, mdealt, merr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_hand();
    test_scores();
    test_wrap();
    test_simultaneous();
    test_held_strobe();
    test_reset_mid_hand();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/baccarat_datapath.md
# baccarat_datapath

Card datapath for the baccarat engine. Sits directly downstream of the dealing state machine: it consumes that FSM's six `load_*` strobes and produces the `pscore`, `dscore` and `pcard3` values the FSM decides on. It contains:
- the card source (deck);
- six card registers;
- hand-score arithmetic;
- a dealt-card counter and a misuse flag.

## Interface
Parameters:
- none

Ports:
- `slow_clock`  in  1  sole clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `load_pcard1`, `load_pcard2`, `load_pcard3`  in  1 each  capture the current deck card into the player card register
- `load_dcard1`, `load_dcard2`, `load_dcard3`  in  1 each  capture the current deck card into the dealer card register
- `pcard1`, `pcard2`, `pcard3`  out  4 each  player card ranks: 0 = no card, 1..13 = A..K
- `dcard1`, `dcard2`, `dcard3`  out  4 each  dealer card ranks, same encoding
- `pscore`  out  4  player hand score, 0..9
- `dscore`  out  4  dealer hand score, 0..9
- `cards_dealt`  out  3  number of accepted loads, 0..6
- `deal_error`  out  1  sticky flag: a load targeted an already-filled register

## Operation
- **Deck (default build):** 4-bit counter `deck`.
  - Reset value is 1.
  - Increments every clock edge; wraps 13 -> 1.
  - Values 0, 14 and 15 never appear.
- **Card registers:** six 4-bit registers, all reset to 0.
  - On an edge where `load_X` = 1 and register X = 0: register X <= `deck`, the value present before that edge.
- **Occupied register:** on an edge where `load_X` = 1 and register X != 0:
  - register X is unchanged;
  - `deal_error` <= 1.
- **Simultaneous loads:** every targeted empty register captures the same `deck` value.
  - `cards_dealt` increases by the number of accepted loads in that edge.
  - `cards_dealt` saturates at 6.
- **Card value:**
  - ranks 1..9 -> 1..9;
  - ranks 10..13 -> 0;
  - rank 0 (empty) -> 0.
- **Scores:** `pscore` = (val(`pcard1`) + val(`pcard2`) + val(`pcard3`)) mod 10; `dscore` is the same over the dealer cards.
  - Compute the sum 5 bits wide (maximum 27), then reduce mod 10.
  - Both scores are combinational from the registers; no extra register stage.
- **`deal_error`:** cleared only by `reset`.
- **`reset`:** has priority over all loads.
  - It returns every register, `deck`, `cards_dealt` and `deal_error` to reset values on the same edge, including mid-hand.
- **No FSM:** the block has no state machine of its own; sequencing is owned by the upstream FSM.

## Timing
- **Reset values:**
  - all card outputs 0;
  - `pscore` = `dscore` = 0;
  - `cards_dealt` = 0;
  - `deal_error` = 0;
  - internal `deck` = 1.
- **Deck sequence:** edge index k counts from the first edge with `reset` = 0, starting at k = 0. At edge k the value captured is (k mod 13) + 1.
- **Load latency:** a load sampled at edge k shows its card on the output after edge k. The affected score is valid in the same cycle, so the FSM sees the updated score one edge later.
- **Load strobes:** level-sampled. A strobe held high for N edges attempts N loads; the first is accepted, and the remaining N-1 set `deal_error`.
- **Reset during a load edge:** the load is discarded.

## Configuration
- **`BACCARAT_DEAL_LFSR_EN` defined:** the deck is an 8-bit Fibonacci LFSR.
  - Taps 8, 6, 5, 4; shifts every edge.
  - Reset seed 8'h01.
  - Card = (lfsr mod 13) + 1, so ranks stay in 1..13.
  - All other behaviour is identical.
- **Undefined:** counter deck as described above. This is the default, and the mode used by the test plan.

## Test plan
- Reset, then loads at k = 0,1,2,3 in order pcard1, dcard1, pcard2, dcard2 -> `pcard1`=1, `dcard1`=2, `pcard2`=3, `dcard2`=4, `pscore`=4, `dscore`=6, `cards_dealt`=4.
- Idle to k = 8, load `pcard1`; k = 12, load `pcard2` -> cards 9 and 13 -> `pscore`=9. Then k = 19, load `pcard3` -> card 7, `pscore`=6.
- Wrap: no loads until k = 13, load `dcard1` -> `dcard1`=1. At k = 25, load `dcard2` -> card 13 -> `dscore`=1.
- Simultaneous `load_pcard3` and `load_dcard3` at k = 5 -> both 6, `cards_dealt`=2, `deal_error`=0.
- `load_pcard1` held for 3 edges from k = 0 -> `pcard1`=1 unchanged, `cards_dealt`=1, `deal_error`=1. It stays 1 until `reset`.
- Assert `reset` with all six cards loaded and a load pending -> next cycle all outputs 0 and the load is discarded. Next capture is rank 1.
